// File: rtl/debug_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : debug_dump_tx
// Description : Streams the register file (32 words) followed by RAM_WORDS
//               data-memory words over an 8N1 UART line, MSB byte first,
//               once per rising edge of the program-finished flag.
//               Optional macro DEBUG_DUMP_FRAMING_EN adds a 0xA5 header byte
//               and a 0x5A trailer byte around the payload.
//               CLKS_PER_BIT must be at least 4: the next word is fetched
//               inside the last stop bit of the previous word, so that
//               consecutive frames have no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_dump_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int RAM_WORDS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fin,
  input  logic [31:0] datoFR,
  input  logic [31:0] datoRAM,
  output logic [4:0]  direccionFR,
  output logic [31:0] direccionRAM,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int c_CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_ITEM_W = 11;

  // Items are sent in order: [header], 32 registers, RAM words, [trailer].
`ifdef DEBUG_DUMP_FRAMING_EN
  localparam int c_BASE      = 1;
  localparam int c_LAST_ITEM = 32 + RAM_WORDS + 1;
`else
  localparam int c_BASE      = 0;
  localparam int c_LAST_ITEM = 32 + RAM_WORDS - 1;
`endif

  localparam logic [c_CNT_W-1:0]  c_CNT_MAX    = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0]  c_STOP_FULL  = c_CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [c_CNT_W-1:0]  c_STOP_FETCH = c_CNT_W'(CLKS_PER_BIT - 4);
  localparam logic [c_ITEM_W-1:0] c_ITEM_LAST  = c_ITEM_W'(c_LAST_ITEM);
  localparam logic [c_ITEM_W-1:0] c_ITEM_BASE  = c_ITEM_W'(c_BASE);
  localparam logic [c_ITEM_W-1:0] c_ITEM_RAM0  = c_ITEM_W'(c_BASE + 32);
  localparam logic [c_ITEM_W-1:0] c_NREG       = c_ITEM_W'(32);
  localparam logic [c_ITEM_W-1:0] c_NRAM       = c_ITEM_W'(RAM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_fin_q;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [2:0]            r_bit;
  logic [1:0]            r_bytes_left;
  logic [c_ITEM_W-1:0]   r_item;
  logic [31:0]           r_shift;

  logic                  w_start;
  logic                  w_bit_end;
  logic                  w_last_item;
  logic                  w_is_reg;
  logic                  w_is_ram;
  logic                  w_cnt_run;
  logic [c_CNT_W-1:0]    w_stop_end;
  logic [c_ITEM_W-1:0]   w_reg_idx;
  logic [c_ITEM_W-1:0]   w_ram_idx;
  logic [31:0]           w_load_word;
  logic [1:0]            w_load_bytes;
  logic [7:0]            w_byte;

  assign w_start     = fin & ~r_fin_q;
  assign w_bit_end   = (r_cnt == c_CNT_MAX);
  assign w_last_item = (r_item == c_ITEM_LAST);
  // Out-of-range items wrap to large unsigned values, so one compare suffices.
  assign w_reg_idx   = r_item - c_ITEM_BASE;
  assign w_ram_idx   = r_item - c_ITEM_RAM0;
  assign w_is_reg    = (w_reg_idx < c_NREG);
  assign w_is_ram    = (w_ram_idx < c_NRAM);
  assign w_byte      = r_shift[31:24];

  // The stop bit also covers NEXT (and FETCH/LOAD when a new item is needed),
  // so STOP itself ends early by the number of those extra cycles.
  assign w_stop_end = ((r_bytes_left == 2'd0) && !w_last_item) ? c_STOP_FETCH : c_STOP_FULL;

  // Baud counter runs through every frame state; the very first FETCH/LOAD
  // of a dump happens before any frame, so it must not advance the counter.
  assign w_cnt_run = (r_state == S_START) || (r_state == S_DATA) ||
                     (r_state == S_STOP)  || (r_state == S_NEXT) ||
                     (((r_state == S_FETCH) || (r_state == S_LOAD)) && (r_item != '0));

  // Select the word to latch and how many further bytes follow its first one.
  always_comb begin
    w_load_word  = 32'h0;
    w_load_bytes = 2'd3;
    if (w_is_reg) begin
      w_load_word = datoFR;
    end else if (w_is_ram) begin
      w_load_word = datoRAM;
    end
`ifdef DEBUG_DUMP_FRAMING_EN
    else if (r_item == '0) begin
      w_load_word  = {8'hA5, 24'h0};
      w_load_bytes = 2'd0;
    end else begin
      w_load_word  = {8'h5A, 24'h0};
      w_load_bytes = 2'd0;
    end
`endif
  end

  // Previous-value flop for fin rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fin_q <= 1'b0;
    else       r_fin_q <= fin;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state and line/status outputs.
  always_comb begin
    w_next = r_state;
    tx     = 1'b1;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_start) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: begin
        tx = 1'b0;
        if (w_bit_end) w_next = S_DATA;
      end
      S_DATA: begin
        tx = w_byte[r_bit];
        if (w_bit_end && (r_bit == 3'd7)) w_next = S_STOP;
      end
      S_STOP: begin
        if (r_cnt == w_stop_end) w_next = S_NEXT;
      end
      S_NEXT: begin
        if (r_bytes_left != 2'd0) w_next = S_START;
        else if (w_last_item)     w_next = S_DONE;
        else                      w_next = S_FETCH;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!fin) w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Baud counter: 0..CLKS_PER_BIT-1, wrapping at each bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_cnt <= '0;
    else if (w_cnt_run) r_cnt <= w_bit_end ? '0 : r_cnt + c_CNT_W'(1);
    else                r_cnt <= '0;
  end

  // Datapath: item/byte/bit sequencing, debug addresses and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_item       <= '0;
      r_bit        <= '0;
      r_bytes_left <= '0;
      r_shift      <= '0;
      direccionFR  <= '0;
      direccionRAM <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_item <= '0;
          r_bit  <= '0;
        end
        S_FETCH: begin
          if (w_is_reg) begin
            direccionFR  <= w_reg_idx[4:0];
            direccionRAM <= '0;
          end else if (w_is_ram) begin
            direccionFR  <= '0;
            direccionRAM <= 32'(w_ram_idx);
          end
        end
        S_LOAD: begin
          r_shift      <= w_load_word;
          r_bytes_left <= w_load_bytes;
        end
        S_DATA: begin
          if (w_bit_end) r_bit <= r_bit + 3'd1;
        end
        S_NEXT: begin
          if (r_bytes_left != 2'd0) begin
            r_shift      <= {r_shift[23:0], 8'h00};
            r_bytes_left <= r_bytes_left - 2'd1;
          end else if (!w_last_item) begin
            r_item <= r_item + c_ITEM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/debug_dump_tx.md
DEBUG_DUMP_TX -- requirements
Module: debug_dump_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200 baud).
REQ-002 The block SHALL have parameter RAM_WORDS, default 32, giving the number of data-memory words dumped, legal range 1..1024.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fin  input  1  program-finished flag from the MEM/WB latch.
REQ-006 datoFR  input  32  register-file read data for direccionFR.
REQ-007 datoRAM  input  32  data-memory debug read data for direccionRAM.
REQ-008 direccionFR  output  5  register-file debug read address.
REQ-009 direccionRAM  output  32  data-memory debug word address.
REQ-010 tx  output  1  UART serial line, idle high.
REQ-011 busy  output  1  high while a dump is in progress.
REQ-012 done  output  1  high after a dump completes, until fin falls.

Function
REQ-013 A dump SHALL start on a fin 0->1 transition, detected by a registered previous-value flop (fin_q).
REQ-014 States SHALL be: IDLE, FETCH, LOAD, START, DATA, STOP, NEXT, DONE.
REQ-015 IDLE->FETCH on the start condition; busy=1 from the FETCH cycle.
REQ-016 In FETCH, the address SHALL be driven for exactly one cycle; in LOAD, the 32-bit word SHALL be latched into a shift register.
REQ-017 Each word SHALL be sent as 4 bytes, most-significant byte first.
REQ-018 Each byte frame: START = tx 0 for CLKS_PER_BIT cycles; DATA = 8 bits, LSB first, CLKS_PER_BIT cycles each; STOP = tx 1 for CLKS_PER_BIT cycles.
REQ-019 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-020 Dump order: registers 0..31 via direccionFR, then RAM word indices 0..RAM_WORDS-1 via direccionRAM (word address = index, no byte scaling).
REQ-021 NEXT SHALL advance to the next byte of the current word, or to FETCH for the next word, or to DONE after the last byte of RAM word RAM_WORDS-1.
REQ-022 Total payload SHALL be 128 + 4*RAM_WORDS bytes, with no idle gap between a STOP bit and the next START bit.
REQ-023 direccionFR and direccionRAM SHALL hold their last value outside FETCH/LOAD; the unused address SHALL be 0.
REQ-024 DONE: busy=0, done=1, tx=1; DONE->IDLE when fin=0.
REQ-025 fin edges while busy or in DONE SHALL be ignored; a new dump requires returning to IDLE and a fresh 0->1 edge.
REQ-026 If fin is already high when reset is released, this SHALL count as a rising edge (fin_q resets to 0).

Reset
REQ-027 Asserting reset, including mid-frame, SHALL immediately force: state IDLE, tx=1, busy=0, done=0, direccionFR=0, direccionRAM=0, fin_q=0, all counters 0.
REQ-028 After reset deassertion, the first transition SHALL occur no earlier than the next clk rising edge.

Configuration
REQ-029 With macro DEBUG_DUMP_FRAMING_EN defined, the block SHALL send header byte 0xA5 before register 0 and trailer byte 0x5A after the last RAM word, both using the REQ-018 framing.
REQ-030 Without DEBUG_DUMP_FRAMING_EN, only the payload bytes SHALL be sent, and framing logic SHALL be absent.

Verification (CLKS_PER_BIT=4, RAM_WORDS=2 unless noted)
REQ-031 Register r1=0x12345678, others 0, RAM 0; pulse fin -> byte stream 00 00 00 00 12 34 56 78 followed by 128 zero bytes; done rises after 136*10*4 cycles.
REQ-032 Single byte 0xA5 sent (framing enabled) -> tx pattern 0,1,0,1,0,0,1,0,1,1 per bit, each bit held 4 cycles.
REQ-033 Assert reset during bit 3 of byte 20 -> tx=1 in the same cycle, busy=0; after release with fin=1 a full dump restarts from register 0.
REQ-034 Toggle fin 0->1->0->1 while busy -> exactly one dump; done stays 0 until the last STOP bit ends.
REQ-035 RAM_WORDS=1, RAM[0]=0xDEADBEEF -> last four payload bytes DE AD BE EF; direccionRAM never exceeds 0.
REQ-036 Build with and without DEBUG_DUMP_FRAMING_EN -> byte counts of 138 and 136 respectively for RAM_WORDS=2.
